uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter among N_REQ byte-stream requesters (e.g. debug unit, core MMIO console, status reporter).
- Grants round-robin at packet granularity: once a requester is granted, it keeps the transmitter until a byte flagged last has been fully sent.
- Sits between the requesters and the transceiver TX interface (tx_data/tx_start/tx_busy/tx_done).
- A starvation timeout releases a lock if the holder stalls mid-packet.

---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked arbiter sharing one UART transmitter
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  localparam int GW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [7:0]         tx_data_o,
  output logic               tx_start_o,
  input  logic               tx_busy_i,
  input  logic               tx_done_i,
  output logic [GW-1:0]      grant_o,
  output logic               active_o,
  output logic               timeout_o
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_START, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_q, rr_d;
  logic          active_q, active_d;
  logic          last_q, last_d;
  logic [7:0]    data_q, data_d;
  logic          start_q, start_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          gnt_valid;
  logic          accept;
  logic          expire;
  logic [CW-1:0] cnt_inc;
  logic [GW-1:0] rr_next;
  logic [GW:0]   cand;
  logic [GW-1:0] pick_idx;

  assign gnt_valid = req_valid_i[grant_q];
  assign accept    = (state_q == S_ISSUE) && gnt_valid && !tx_busy_i;
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  // Only a stalled holder (valid low) ages the lock; a busy line never does.
  assign expire    = (TIMEOUT_CYCLES != 0) && (state_q == S_ISSUE) && !gnt_valid
                     && (cnt_inc == CW'(TIMEOUT_CYCLES));
  assign rr_next   = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

  // Walk from the highest offset down so the nearest valid index to rr_q wins.
  always_comb begin
    cand     = '0;
    pick_idx = rr_q;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_q} + (GW+1)'(i);
      if (cand >= (GW+1)'(N_REQ)) cand = cand - (GW+1)'(N_REQ);
      if (req_valid_i[cand[GW-1:0]]) pick_idx = cand[GW-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      active_q  <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      active_q  <= active_d;
      last_q    <= last_d;
      data_q    <= data_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|req_valid_i) state_d = S_ISSUE;
      S_ISSUE: begin
        if (accept)      state_d = S_START;
        else if (expire) state_d = S_IDLE;
      end
      S_START: state_d = S_WAIT;
      S_WAIT:  if (tx_done_i) state_d = last_q ? S_IDLE : S_ISSUE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d     = grant_q;
    rr_d        = rr_q;
    active_d    = active_q;
    last_d      = last_q;
    data_d      = data_q;
    start_d     = 1'b0;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;
    req_ready_o = '0;
    req_ready_o[grant_q] = accept;
    case (state_q)
      S_IDLE: begin
        if (|req_valid_i) begin
          grant_d  = pick_idx;
          active_d = 1'b1;
          cnt_d    = '0;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          data_d  = req_data_i[8*grant_q +: 8];
          last_d  = req_last_i[grant_q];
          start_d = 1'b1;
          cnt_d   = '0;
        end else if (!gnt_valid) begin
          cnt_d = cnt_inc;
          if (expire) begin
            timeout_d = 1'b1;
            active_d  = 1'b0;
            rr_d      = rr_next;
            cnt_d     = '0;
          end
        end
      end
      S_WAIT: begin
        if (tx_done_i && last_q) begin
          active_d = 1'b0;
          rr_d     = rr_next;
        end
      end
      default: ;
    endcase
  end

  assign tx_data_o  = data_q;
  assign tx_start_o = start_q;
  assign grant_o    = grant_q;
  assign active_o   = active_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int NR       = 4;
  localparam int BYTE_CYC = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [NR-1:0] req_valid_i;
  logic [8*NR-1:0] req_data_i;
  logic [NR-1:0] req_last_i;
  logic [NR-1:0] req_ready_o;
  logic [7:0]    tx_data_o;
  logic          tx_start_o;
  logic          tx_busy_i;
  logic          tx_done_i;
  logic [1:0]    grant_o;
  logic          active_o;
  logic          timeout_o;

  uart_tx_arbiter #(.N_REQ(NR), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .tx_data_o(tx_data_o), .tx_start_o(tx_start_o),
    .tx_busy_i(tx_busy_i), .tx_done_i(tx_done_i), .grant_o(grant_o),
    .active_o(active_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] mask;
    int         nb;
    int         npk;
    logic [7:0] order;
  } vec_t;

  vec_t       vecs [8];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] rmem [NR][16];
  int         head [NR];
  int         tail [NR];
  logic [NR-1:0] hs_q;
  logic [7:0] exp_q [$];
  int         served [$];
  int         mdl_cnt;
  logic       force_busy;
  logic       seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input int k, input logic [7:0] d, input logic last);
    if (head[k] == tail[k]) begin
      head[k] = 0;
      tail[k] = 0;
    end
    rmem[k][tail[k]] = {last, d};
    tail[k]++;
  endtask

  // One cycle: retire last handshake, run the transceiver model, drive requesters, sample.
  task automatic tick();
    logic [NR-1:0] hs;
    @(negedge clk_i);
    for (int k = 0; k < NR; k++) if (hs_q[k]) head[k]++;
    hs_q = '0;
    tx_done_i = 1'b0;
    if (mdl_cnt > 0) begin
      mdl_cnt--;
      if (mdl_cnt == 0) tx_done_i = 1'b1;
    end
    if (tx_start_o) begin
      check("start_while_busy", tx_busy_i, 0);
      check("sb_start_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("sb_tx_data", tx_data_o, exp_q.pop_front());
      mdl_cnt = BYTE_CYC;
    end
    tx_busy_i = force_busy | (mdl_cnt > 0);
    for (int k = 0; k < NR; k++) begin
      req_valid_i[k] = head[k] < tail[k];
      req_data_i[8*k +: 8] = req_valid_i[k] ? rmem[k][head[k]][7:0] : 8'h00;
      req_last_i[k] = req_valid_i[k] ? rmem[k][head[k]][8] : 1'b0;
    end
    #1;
    check("ready_onehot", $countones(req_ready_o) <= 1, 1);
    hs = req_ready_o & req_valid_i;
    for (int k = 0; k < NR; k++) begin
      if (hs[k]) begin
        exp_q.push_back(req_data_i[8*k +: 8]);
        served.push_back(k);
      end
    end
    hs_q = hs;
  endtask

  function automatic logic idle_now();
    logic r;
    r = !active_o && !tx_start_o && (mdl_cnt == 0) && (exp_q.size() == 0) && (hs_q == '0);
    for (int k = 0; k < NR; k++) if (head[k] != tail[k]) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = idle_now();
    end
    check(name, done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{mask: 4'b0001, nb: 1, npk: 1, order: {2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[1] = '{mask: 4'b0111, nb: 1, npk: 3, order: {2'd0, 2'd0, 2'd2, 2'd1}};
    vecs[2] = '{mask: 4'b1001, nb: 1, npk: 2, order: {2'd0, 2'd0, 2'd0, 2'd3}};
    vecs[3] = '{mask: 4'b1111, nb: 2, npk: 4, order: {2'd0, 2'd3, 2'd2, 2'd1}};
    vecs[4] = '{mask: 4'b0100, nb: 1, npk: 1, order: {2'd0, 2'd0, 2'd0, 2'd2}};
    vecs[5] = '{mask: 4'b1011, nb: 3, npk: 3, order: {2'd0, 2'd1, 2'd0, 2'd3}};
    vecs[6] = '{mask: 4'b0011, nb: 1, npk: 2, order: {2'd0, 2'd0, 2'd1, 2'd0}};
    vecs[7] = '{mask: 4'b1000, nb: 1, npk: 1, order: {2'd0, 2'd0, 2'd0, 2'd3}};

    for (int k = 0; k < NR; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    hs_q = '0;
    mdl_cnt = 0;
    force_busy = 1'b0;
    req_valid_i = '0;
    req_data_i = '0;
    req_last_i = '0;
    tx_busy_i = 1'b0;
    tx_done_i = 1'b0;
    rst_ni = 1'b0;

    repeat (3) tick();
    check("rst_ready", req_ready_o, 0);
    check("rst_data", tx_data_o, 0);
    check("rst_start", tx_start_o, 0);
    check("rst_grant", grant_o, 0);
    check("rst_active", active_o, 0);
    check("rst_timeout", timeout_o, 0);
    rst_ni = 1'b1;

    // Round-robin order over single and multi-byte packets; rr pointer carries between rows.
    for (int v = 0; v < 8; v++) begin
      served.delete();
      for (int k = 0; k < NR; k++)
        if (vecs[v].mask[k])
          for (int b = 0; b < vecs[v].nb; b++)
            load(k, 8'(v*16 + k*4 + b), b == vecs[v].nb - 1);
      drain($sformatf("vec%0d_drain", v), 500);
      check($sformatf("vec%0d_count", v), served.size(), vecs[v].npk * vecs[v].nb);
      for (int p = 0; p < vecs[v].npk; p++)
        for (int b = 0; b < vecs[v].nb; b++)
          if (p*vecs[v].nb + b < served.size())
            check($sformatf("vec%0d_order_%0d", v, p*vecs[v].nb + b),
                  served[p*vecs[v].nb + b], vecs[v].order[2*p +: 2]);
    end

    // Single request timing.
    served.delete();
    load(0, 8'h41, 1'b1);
    tick();
    check("single_idle_ready", req_ready_o, 0);
    tick();
    check("single_ready", req_ready_o, 4'b0001);
    check("single_active", active_o, 1);
    check("single_grant", grant_o, 0);
    tick();
    check("single_start", tx_start_o, 1);
    check("single_data", tx_data_o, 8'h41);
    check("single_ready_off", req_ready_o, 0);
    tick();
    check("single_start_pulse", tx_start_o, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = tx_done_i;
    end
    check("single_done_seen", seen, 1);
    check("single_active_at_done", active_o, 1);
    tick();
    check("single_active_fall", active_o, 0);
    drain("single_drain", 50);

    // Packet lock: req1 keeps the line for its whole packet while req0 waits.
    served.delete();
    load(1, 8'h10, 1'b0);
    load(1, 8'h11, 1'b0);
    load(1, 8'h12, 1'b1);
    tick();
    tick();
    check("lock_grant", grant_o, 1);
    load(0, 8'h55, 1'b1);
    drain("lock_drain", 200);
    check("lock_count", served.size(), 4);
    if (served.size() == 4) begin
      check("lock_0", served[0], 1);
      check("lock_1", served[1], 1);
      check("lock_2", served[2], 1);
      check("lock_3", served[3], 0);
    end

    // Busy gating: a held valid against a busy line neither issues nor ages the lock.
    served.delete();
    force_busy = 1'b1;
    load(2, 8'h7E, 1'b1);
    tick();
    for (int i = 0; i < 50; i++) begin
      tick();
      check("busy_ready", req_ready_o, 0);
      check("busy_start", tx_start_o, 0);
      check("busy_timeout", timeout_o, 0);
    end
    force_busy = 1'b0;
    tick();
    check("busy_release_ready", req_ready_o, 4'b0100);
    tick();
    check("busy_release_start", tx_start_o, 1);
    check("busy_release_data", tx_data_o, 8'h7E);
    drain("busy_drain", 50);

    // Timeout: req2 stalls mid-packet, lock is released to req3.
    served.delete();
    load(2, 8'h20, 1'b0);
    for (int i = 0; i < 20 && served.size() == 0; i++) tick();
    check("to_first_grant", (served.size() > 0) ? served[0] : -1, 2);
    load(3, 8'h33, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = tx_done_i;
    end
    check("to_done_seen", seen, 1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("to_wait_%0d_pulse", i), timeout_o, 0);
      check("to_wait_no_ready", req_ready_o, 0);
      check("to_wait_active", active_o, 1);
    end
    tick();
    check("to_pulse", timeout_o, 1);
    check("to_active_off", active_o, 0);
    tick();
    check("to_pulse_end", timeout_o, 0);
    check("to_next_grant", grant_o, 3);
    check("to_next_ready", req_ready_o, 4'b1000);
    drain("to_drain", 50);

    // Async reset during S_WAIT, then arbitration restarts from pointer 0.
    served.delete();
    load(2, 8'h5A, 1'b1);
    drain("rst_pre_drain", 50);
    load(1, 8'h66, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = tx_start_o;
    end
    check("rst_start_seen", seen, 1);
    tick();
    check("rst_pre_active", active_o, 1);
    check("rst_pre_grant", grant_o, 1);
    rst_ni = 1'b0;
    #1;
    check("arst_ready", req_ready_o, 0);
    check("arst_data", tx_data_o, 0);
    check("arst_start", tx_start_o, 0);
    check("arst_grant", grant_o, 0);
    check("arst_active", active_o, 0);
    check("arst_timeout", timeout_o, 0);
    mdl_cnt = 0;
    tx_busy_i = 1'b0;
    tx_done_i = 1'b0;
    hs_q = '0;
    exp_q.delete();
    for (int k = 0; k < NR; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    tick();
    rst_ni = 1'b1;
    served.delete();
    load(1, 8'h71, 1'b1);
    load(3, 8'h73, 1'b1);
    tick();
    tick();
    check("arst_regrant", grant_o, 1);
    check("arst_regrant_ready", req_ready_o, 4'b0010);
    drain("arst_drain", 100);
    check("arst_count", served.size(), 2);
    if (served.size() == 2) check("arst_second", served[1], 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
